// File: rtl/irq_arbiter.sv
// Level-sensitive interrupt arbiter: lowest vector wins, REQ/ACK handshake, RETI hold-off.
// Optional last-vector IO register enabled by defining IRQ_ARB_LASTVEC_EN.
module irq_arbiter #(
    parameter int          IRQ_NUM          = 45,
    parameter logic [5:0]  LASTVEC_Address  = 6'h3A
) (
    input  logic               cp2,
    input  logic               ireset,
    input  logic [IRQ_NUM-1:0] irqlines,
    input  logic               sreg_i,
    input  logic               cpu_irq_accept,
    input  logic               reti_exec,
    input  logic               instr_done,
    output logic               irq_req,
    output logic [5:0]         irq_vector,
    output logic               irqack,
    output logic [5:0]         irqack_addr,
    input  logic [5:0]         IO_Addr,
    input  logic               iore,
    output logic [7:0]         dbus_out,
    output logic               out_en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t     state_q;
    logic       irq_req_q;
    logic [5:0] irq_vector_q;
    logic       irqack_q;
    logic [5:0] irqack_addr_q;
    logic       pending;
    logic [5:0] sel_vec;

    // Scan downward so the lowest set line is the last one written.
    always_comb begin
        sel_vec = 6'd0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (irqlines[i]) sel_vec = 6'(i + 1);
        end
    end

    assign pending = |irqlines;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q       <= IDLE;
            irq_req_q     <= 1'b0;
            irq_vector_q  <= 6'd0;
            irqack_q      <= 1'b0;
            irqack_addr_q <= 6'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (reti_exec) begin
                        state_q <= HOLD;
                    end else if (sreg_i && pending) begin
                        state_q      <= REQ;
                        irq_req_q    <= 1'b1;
                        irq_vector_q <= sel_vec;
                    end
                end
                REQ: begin
                    // The address acked is what the core saw, not the live lines.
                    if (cpu_irq_accept) begin
                        state_q       <= ACK;
                        irq_req_q     <= 1'b0;
                        irqack_q      <= 1'b1;
                        irqack_addr_q <= irq_vector_q;
                    end else if (reti_exec) begin
                        state_q   <= HOLD;
                        irq_req_q <= 1'b0;
                    end else if (!sreg_i || !pending) begin
                        state_q   <= IDLE;
                        irq_req_q <= 1'b0;
                    end else begin
                        irq_vector_q <= sel_vec;
                    end
                end
                ACK: begin
                    state_q       <= IDLE;
                    irqack_q      <= 1'b0;
                    irqack_addr_q <= 6'd0;
                end
                HOLD: begin
                    if (instr_done) state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                    irqack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req     = irq_req_q;
    assign irq_vector  = irq_vector_q;
    assign irqack      = irqack_q;
    assign irqack_addr = irqack_addr_q;

`ifdef IRQ_ARB_LASTVEC_EN
    logic [7:0] lastvec_q;
    logic       rd_hit;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            lastvec_q <= 8'd0;
        end else if (state_q == ACK) begin
            lastvec_q <= {2'b00, irqack_addr_q};
        end
    end

    // Gated by reset so the bus stays quiet while held in reset.
    assign rd_hit   = ireset && iore && (IO_Addr == LASTVEC_Address);
    assign dbus_out = rd_hit ? lastvec_q : 8'd0;
    assign out_en   = rd_hit;
`else
    logic unused_io;
    assign unused_io = ^{IO_Addr, iore, LASTVEC_Address};
    assign dbus_out  = 8'd0;
    assign out_en    = 1'b0;
`endif

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 45, number of request lines; line i maps to vector i+1; legal range 1..62.
REQ-002 SHALL have parameter LASTVEC_Address, default 6'h3A, IO address of the last-vector register (only used when IRQ_ARB_LASTVEC_EN is defined).
REQ-003 SHALL have port cp2, input, 1, the single clock, rising edge.
REQ-004 SHALL have port ireset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port irqlines, input, IRQ_NUM, level IRQ requests from peripherals; bit 0 is INT0 (vector 1).
REQ-006 SHALL have port sreg_i, input, 1, global interrupt enable (SREG I).
REQ-007 SHALL have port cpu_irq_accept, input, 1, one-cycle strobe from core taking the presented interrupt.
REQ-008 SHALL have port reti_exec, input, 1, one-cycle strobe on RETI completion.
REQ-009 SHALL have port instr_done, input, 1, one-cycle strobe at each instruction boundary.
REQ-010 SHALL have port irq_req, output, 1, registered interrupt request to core.
REQ-011 SHALL have port irq_vector, output, 6, registered vector presented with irq_req.
REQ-012 SHALL have port irqack, output, 1, one-cycle acknowledge to peripherals.
REQ-013 SHALL have port irqack_addr, output, 6, vector being acknowledged, valid while irqack=1.
REQ-014 SHALL have ports IO_Addr (input, 6), iore (input, 1), dbus_out (output, 8), out_en (output, 1) for IO reads.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, ACK, HOLD; irq_req=1 only in REQ, irqack=1 only in ACK.
REQ-016 SHALL select the pending vector as lowest set index of irqlines plus 1 (lowest vector number wins), 6-bit result.
REQ-017 IDLE -> REQ at a rising edge sampling sreg_i=1 and any irqlines bit set; irq_vector loaded with the selected vector at that edge.
REQ-018 In REQ, irq_vector SHALL be re-evaluated every edge, so a higher-priority line arriving before accept replaces the vector.
REQ-019 REQ -> IDLE at an edge sampling sreg_i=0 or no irqlines bit set, unless cpu_irq_accept=1 at that edge.
REQ-020 REQ -> ACK at an edge sampling cpu_irq_accept=1; irqack_addr frozen to the irq_vector value presented during that cycle, even if the line dropped in the same cycle.
REQ-021 ACK lasts exactly one cycle, then -> IDLE; irq_vector holds its value.
REQ-022 cpu_irq_accept outside REQ SHALL be ignored.
REQ-023 reti_exec sampled in IDLE or REQ SHALL force -> HOLD, dropping irq_req; in ACK it SHALL be ignored (accept wins).
REQ-024 HOLD -> IDLE at the first edge sampling instr_done=1, guaranteeing one instruction executes after RETI before the next request.
REQ-025 irqack_addr SHALL read 6'h00 whenever irqack=0.

Reset
REQ-026 ireset low SHALL asynchronously force state IDLE, irq_req=0, irq_vector=0, irqack=0, irqack_addr=0, last-vector register=0, dbus_out=0, out_en=0; reset during ACK drops irqack immediately.

Configuration
REQ-027 Macro IRQ_ARB_LASTVEC_EN defined: 8-bit read-only register {2'b00, vector} loaded in ACK; when iore=1 and IO_Addr==LASTVEC_Address, dbus_out=register and out_en=1, else dbus_out=0, out_en=0.
REQ-028 Macro IRQ_ARB_LASTVEC_EN undefined: no register; dbus_out tied 0, out_en tied 0; ports remain.

Verification
REQ-029 sreg_i=1, irqlines[0] raised -> irq_req=1, irq_vector=1 next edge; accept pulse -> irqack=1 with irqack_addr=1 for exactly one cycle.
REQ-030 irqlines[5] then irqlines[1] one cycle later, no accept -> irq_vector 6 then 2; accept -> irqack_addr=2.
REQ-031 In REQ, line dropped with no accept -> back to IDLE, irq_req=0, no irqack.
REQ-032 reti_exec with irqlines[3] high, sreg_i=1 -> irq_req stays 0 until instr_done, then vector 4 requested next edge.
REQ-033 ireset asserted during ACK -> irqack=0 immediately; all outputs 0.
REQ-034 With IRQ_ARB_LASTVEC_EN, after acking vector 27, IO read at 6'h3A -> dbus_out=8'h1B, out_en=1; without macro -> out_en=0.
